// File: rtl/fifo_drain_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
//
// Purpose: shared types and sizing helpers for the FIFO drain arbiter and its
// round-robin picker.
//
// Contents:
//   arb_state_t    - arbiter FSM state (IDLE waits for a pending channel,
//                    DRAIN pops words from the granted channel)
//   calc_gw()      - width of a channel index for N channels, never below 1
//   calc_cnt_w()   - width of a counter that must reach MAX_BURST
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } arb_state_t;

  // Index width for n channels. Two channels still need one bit, so the
  // result is clamped to a minimum of 1.
  function automatic int calc_gw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Width of the per-grant pop counter. It has to hold MAX_BURST itself, not
  // just MAX_BURST-1, hence the +1 before taking the log.
  function automatic int calc_cnt_w(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/fifo_drain_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//
// Purpose: combinational round-robin picker. Returns the first requesting
// channel strictly after 'last', searching upward and wrapping from N-1
// back to 0. 'last' itself is therefore the lowest-priority channel.
//
// Ports:
//   req   [N-1:0]  in   request vector (one bit per channel)
//   last  [GW-1:0] in   channel granted most recently
//   found          out  at least one request bit is set
//   idx   [GW-1:0] out  chosen channel; 0 when nothing is requested
// ---------------------------------------------------------------------------
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int GW = calc_gw(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic          found,
  output logic [GW-1:0] idx
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] upper_req;

  // Mask of channels numbered strictly above 'last'. These are the channels
  // that come first in the rotated priority order; everything at or below
  // 'last' only gets a turn after the search wraps around.
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < N; i++) begin
      upper_mask[i] = (i > int'(last));
    end
  end

  assign upper_req = req & upper_mask;

  // Two lowest-index-first searches. The unmasked search gives the wrapped
  // answer; the masked search then overrides it whenever a channel above
  // 'last' is requesting, which is exactly the rotated priority order.
  // Scanning downward lets the last hit (the lowest index) win.
  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = GW'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (upper_req[i]) begin
        idx = GW'(i);
      end
    end
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_drain_arbiter
//
// Purpose: round-robin read scheduler sharing one downstream consumer among
// N FIFOs. A channel arms when its FIFO reports full and stays armed until
// it has been drained to empty. Each grant pops at most MAX_BURST words,
// after which the channel goes to the back of the round-robin order.
//
// Parameters:
//   N          number of FIFO channels (2..16)
//   MAX_BURST  maximum pops per grant (>= 1)
//
// Ports:
//   clk                  in   system clock, everything on the rising edge
//   rst_n                in   synchronous active-low reset
//   read_full   [N-1:0]  in   per-channel FIFO full flag
//   read_empty  [N-1:0]  in   per-channel FIFO empty flag
//   sink_ready           in   consumer accepts a word this cycle
//   read_req    [N-1:0]  out  one-hot pop strobe (combinational)
//   grant_valid          out  a channel is currently granted
//   grant_idx   [GW-1:0] out  granted channel
// ---------------------------------------------------------------------------
module fifo_drain_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int MAX_BURST = 8,
  localparam int GW        = calc_gw(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  read_full,
  input  logic [N-1:0]  read_empty,
  input  logic          sink_ready,
  output logic [N-1:0]  read_req,
  output logic          grant_valid,
  output logic [GW-1:0] grant_idx
);

  localparam int            CW         = calc_cnt_w(MAX_BURST);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(MAX_BURST - 1);
  localparam logic [GW-1:0] RESET_LAST = GW'(N - 1);

  arb_state_t    state;
  logic [N-1:0]  pending;
  logic [N-1:0]  pending_nxt;
  logic [GW-1:0] last_grant;
  logic [CW-1:0] burst_cnt;

  logic          pick_found;
  logic [GW-1:0] pick_idx;

  logic          cur_empty;
  logic          cur_full;
  logic          pop;

  // The picker looks at the registered pending set, so a channel that arms
  // in cycle t is first considered in t+1 and drained from t+2 onward.
  rr_pick #(
    .N  (N),
    .GW (GW)
  ) u_pick (
    .req   (pending),
    .last  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign cur_empty = read_empty[grant_idx];
  assign cur_full  = read_full[grant_idx];

  // A pop happens only while draining, when the granted FIFO still has data
  // and the consumer can take it. Gating on the empty flag guarantees we
  // never strobe an empty FIFO.
  assign pop = (state == DRAIN) && !cur_empty && sink_ready;

  // Pop strobe decode. Only the granted channel's bit can ever be set, which
  // keeps the strobe one-hot (or all zero) by construction.
  always_comb begin
    read_req = '0;
    if (pop) begin
      read_req[grant_idx] = 1'b1;
    end
  end

  // Next pending set. Any full flag arms its channel. The granted channel is
  // disarmed when it is found empty, except that a full flag seen in the
  // same cycle re-arms it: setting has priority over clearing so a FIFO that
  // fills again right away is never forgotten. A burst-limit exit leaves the
  // pending bit alone so the channel competes again after the others.
  always_comb begin
    pending_nxt = pending | read_full;
    if ((state == DRAIN) && cur_empty && !cur_full) begin
      pending_nxt[grant_idx] = 1'b0;
    end
  end

  // Arbiter FSM with its registered outputs. In IDLE it grants the next
  // pending channel in round-robin order and clears the burst counter. In
  // DRAIN it counts pops and returns to IDLE either when the FIFO runs empty
  // (possibly on the very first cycle, with zero pops) or when the pop that
  // completes the burst happens. Every exit records the channel as the most
  // recent grant and costs one IDLE cycle before the next grant. While the
  // consumer stalls, nothing moves. Reset starts with last_grant at N-1 so
  // that channel 0 has top priority first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pending     <= '0;
      grant_idx   <= '0;
      last_grant  <= RESET_LAST;
      burst_cnt   <= '0;
      grant_valid <= 1'b0;
    end else begin
      pending <= pending_nxt;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_idx   <= pick_idx;
            burst_cnt   <= '0;
            state       <= DRAIN;
            grant_valid <= 1'b1;
          end
        end
        DRAIN: begin
          if (cur_empty) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            last_grant  <= grant_idx;
          end else if (pop) begin
            burst_cnt <= burst_cnt + CW'(1);
            if (burst_cnt == LAST_BEAT) begin
              state       <= IDLE;
              grant_valid <= 1'b0;
              last_grant  <= grant_idx;
            end
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
